// File: rtl/trigger_pkg.sv
// Shared types for the staged trigger: per-channel mode codes and FSM states.
package trigger_pkg;

  typedef enum logic [2:0] {
    TRIG_DC   = 3'd0,
    TRIG_LOW  = 3'd1,
    TRIG_HIGH = 3'd2,
    TRIG_RISE = 3'd3,
    TRIG_FALL = 3'd4,
    TRIG_EDGE = 3'd5
  } trig_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_MATCHING,
    ST_FIRED
  } trig_state_e;

  localparam int MODE_BITS = 3;

endpackage

// File: rtl/trigger_chan_match.sv
// Combinational single-channel condition check; reserved codes behave as don't-care.
module trigger_chan_match
  import trigger_pkg::*;
(
  input  logic [MODE_BITS-1:0] mode,
  input  logic                 sample,
  input  logic                 prev,
  output logic                 match
);

  trig_mode_e mode_e;
  assign mode_e = trig_mode_e'(mode);

  always_comb begin
    match = 1'b1;
    case (mode_e)
      TRIG_LOW:  match = ~sample;
      TRIG_HIGH: match = sample;
      TRIG_RISE: match = sample & ~prev;
      TRIG_FALL: match = ~sample & prev;
      TRIG_EDGE: match = sample ^ prev;
      default:   match = 1'b1;
    endcase
  end

endmodule

// File: rtl/trigger_staged.sv
// Sequenced multi-stage trigger: each stage needs count+1 matching valid samples,
// the final stage's last qualifying sample raises run on the following cycle.
module trigger_staged
  import trigger_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int NUM_STAGES   = 4,
  parameter int COUNT_WIDTH  = 16,
  localparam int STAGE_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            valid,
  input  logic [SAMPLE_WIDTH-1:0]         dataIn,
  input  logic                            cfg_we,
  input  logic [STAGE_W-1:0]              cfg_stage,
  input  logic [MODE_BITS*SAMPLE_WIDTH-1:0] cfg_mode,
  input  logic [COUNT_WIDTH-1:0]          cfg_count,
  input  logic                            cfg_last,
  input  logic                            arm,
  input  logic                            disarm,
  output logic                            run,
  output logic                            armed,
  output logic [STAGE_W-1:0]              stage_idx,
  output logic                            cfg_err
);

  typedef struct packed {
    logic [MODE_BITS*SAMPLE_WIDTH-1:0] mode;
    logic [COUNT_WIDTH-1:0]            count;
    logic                              last;
  } stage_cfg_t;

  stage_cfg_t               cfg_q [NUM_STAGES];
  stage_cfg_t               cur;
  trig_state_e              state_q, state_d;
  logic [STAGE_W-1:0]       stage_q, stage_d;
  logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0]  prev_q;
  logic [SAMPLE_WIDTH-1:0]  ch_match;
  logic                     stage_match;
  logic                     final_stage;
  logic                     cfg_in_range;

  // Only the active stage's modes reach the comparators.
  assign cur = cfg_q[stage_q];

  for (genvar i = 0; i < SAMPLE_WIDTH; i++) begin : g_chan
    trigger_chan_match u_match (
      .mode   (cur.mode[MODE_BITS*i +: MODE_BITS]),
      .sample (dataIn[i]),
      .prev   (prev_q[i]),
      .match  (ch_match[i])
    );
  end

  assign stage_match  = &ch_match;
  assign final_stage  = cur.last || (stage_q == STAGE_W'(NUM_STAGES - 1));
  assign cfg_in_range = ({1'b0, cfg_stage} < (STAGE_W + 1)'(NUM_STAGES));

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (disarm) begin
      state_d = ST_IDLE;
      stage_d = '0;
      cnt_d   = '0;
    end else if (arm) begin
      state_d = ST_PRIME;
      stage_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_PRIME: if (valid) state_d = ST_MATCHING;
        ST_MATCHING: begin
          if (valid && stage_match) begin
            if (cnt_q == cur.count) begin
              if (final_stage) begin
                state_d = ST_FIRED;
              end else begin
                stage_d = stage_q + 1'b1;
                cnt_d   = '0;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      prev_q  <= '0;
      cfg_err <= 1'b0;
      for (int s = 0; s < NUM_STAGES; s++) cfg_q[s] <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      if (valid) prev_q <= dataIn;
      // A rejected write in the same cycle as arm still leaves the error flagged.
      if (cfg_we && state_q != ST_IDLE) cfg_err <= 1'b1;
      else if (arm)                     cfg_err <= 1'b0;
      if (cfg_we && state_q == ST_IDLE && cfg_in_range) begin
        cfg_q[cfg_stage] <= '{mode: cfg_mode, count: cfg_count, last: cfg_last};
      end
    end
  end

  assign run       = (state_q == ST_FIRED);
  assign armed     = (state_q == ST_PRIME) || (state_q == ST_MATCHING);
  assign stage_idx = stage_q;

endmodule

// File: tb/tb_trigger_staged.sv
// Directed table-driven bench for trigger_staged with hand sequences for config error and reset.
module tb_trigger_staged;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid;
  logic [7:0]  dataIn;
  logic        cfg_we;
  logic [1:0]  cfg_stage;
  logic [23:0] cfg_mode;
  logic [15:0] cfg_count;
  logic        cfg_last;
  logic        arm;
  logic        disarm;
  logic        run;
  logic        armed;
  logic [1:0]  stage_idx;
  logic        cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  trigger_staged #(.SAMPLE_WIDTH(8), .NUM_STAGES(4), .COUNT_WIDTH(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .valid     (valid),
    .dataIn    (dataIn),
    .cfg_we    (cfg_we),
    .cfg_stage (cfg_stage),
    .cfg_mode  (cfg_mode),
    .cfg_count (cfg_count),
    .cfg_last  (cfg_last),
    .arm       (arm),
    .disarm    (disarm),
    .run       (run),
    .armed     (armed),
    .stage_idx (stage_idx),
    .cfg_err   (cfg_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       a;
    logic       da;
    logic       exp_run;
    logic       exp_armed;
    logic [1:0] exp_stage;
  } vec_t;

  vec_t tab[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic cfg(input logic [1:0] s, input logic [23:0] m, input logic [15:0] c, input logic l);
    cfg_we = 1'b1; cfg_stage = s; cfg_mode = m; cfg_count = c; cfg_last = l;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic samp(input logic [7:0] d);
    valid = 1'b1; dataIn = d;
    cyc();
    valid = 1'b0;
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic a, input logic da,
                     input logic r, input logic am, input logic [1:0] st);
    tab.push_back('{v, d, a, da, r, am, st});
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tab.size(); i++) begin
      valid = tab[i].v; dataIn = tab[i].d; arm = tab[i].a; disarm = tab[i].da;
      cyc();
      valid = 1'b0; arm = 1'b0; disarm = 1'b0;
      check($sformatf("%s[%0d].run", tag, i),   32'(run),       32'(tab[i].exp_run));
      check($sformatf("%s[%0d].armed", tag, i), 32'(armed),     32'(tab[i].exp_armed));
      check($sformatf("%s[%0d].stage", tag, i), 32'(stage_idx), 32'(tab[i].exp_stage));
    end
    tab.delete();
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; dataIn = '0; cfg_we = 1'b0; cfg_stage = '0;
    cfg_mode = '0; cfg_count = '0; cfg_last = 1'b0; arm = 1'b0; disarm = 1'b0;
    repeat (2) @(negedge clock);
    check("rst.run", 32'(run), 0);
    check("rst.armed", 32'(armed), 0);
    check("rst.stage", 32'(stage_idx), 0);
    check("rst.cfg_err", 32'(cfg_err), 0);
    reset = 1'b0;
    cyc();

    // ch0 rising, single final stage
    cfg(2'd0, 24'h000003, 16'd0, 1'b1);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(1, 8'h00, 0, 0, 0, 1, 0);
    add(1, 8'h00, 0, 0, 0, 1, 0);
    add(1, 8'h01, 0, 0, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0, 0);
    // re-arm; priming sample already high must not fire
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(1, 8'h01, 0, 0, 0, 1, 0);
    add(1, 8'h00, 0, 0, 0, 1, 0);
    add(1, 8'h01, 0, 0, 1, 0, 0);
    // invalid cycles carrying a would-be edge are ignored
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(1, 8'h00, 0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) add(0, 8'h01, 0, 0, 0, 1, 0);
    add(1, 8'h01, 0, 0, 1, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0, 0);
    run_table("single");

    // three-stage sequence
    cfg(2'd0, 24'h000010, 16'd2, 1'b0);
    cfg(2'd1, 24'h000100, 16'd0, 1'b0);
    cfg(2'd2, 24'h000005, 16'd0, 1'b1);
    check("cfg.no_err_idle", 32'(cfg_err), 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(1, 8'h04, 0, 0, 0, 1, 0);
    add(1, 8'h06, 0, 0, 0, 1, 0);
    add(1, 8'h04, 0, 0, 0, 1, 0);
    add(1, 8'h06, 0, 0, 0, 1, 0);
    add(1, 8'h04, 0, 0, 0, 1, 0);
    add(1, 8'h06, 0, 0, 0, 1, 1);
    add(1, 8'h06, 0, 0, 0, 1, 1);
    add(1, 8'h02, 0, 0, 0, 1, 2);
    add(1, 8'h02, 0, 0, 0, 1, 2);
    add(1, 8'h03, 0, 0, 1, 0, 2);
    run_table("multi");

    // arm and disarm together while matching: disarm wins
    arm = 1'b1; cyc(); arm = 1'b0;
    samp(8'h00);
    samp(8'h02);
    check("ad.pre_armed", 32'(armed), 1);
    arm = 1'b1; disarm = 1'b1; cyc(); arm = 1'b0; disarm = 1'b0;
    check("ad.armed", 32'(armed), 0);
    check("ad.run", 32'(run), 0);
    check("ad.stage", 32'(stage_idx), 0);

    // config write while matching is rejected and flagged
    arm = 1'b1; cyc(); arm = 1'b0;
    samp(8'h00);
    cfg(2'd0, 24'h000000, 16'd0, 1'b1);
    check("cfgerr.set", 32'(cfg_err), 1);
    check("cfgerr.armed", 32'(armed), 1);
    samp(8'h00);
    check("cfgerr.cfg_kept_run", 32'(run), 0);
    check("cfgerr.cfg_kept_stage", 32'(stage_idx), 0);
    arm = 1'b1; cyc(); arm = 1'b0;
    check("cfgerr.clr_by_arm", 32'(cfg_err), 0);
    samp(8'h00);
    samp(8'h02);

    // asynchronous reset mid-match
    #2 reset = 1'b1;
    #1;
    check("areset.run", 32'(run), 0);
    check("areset.armed", 32'(armed), 0);
    check("areset.stage", 32'(stage_idx), 0);
    check("areset.cfg_err", 32'(cfg_err), 0);
    @(negedge clock);
    reset = 1'b0;
    cyc();

    // config lost: all stages don't-care, walks every stage then fires on the last index
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(1, 8'h00, 0, 0, 0, 1, 0);
    add(1, 8'h00, 0, 0, 0, 1, 1);
    add(1, 8'h00, 0, 0, 0, 1, 2);
    add(1, 8'h00, 0, 0, 0, 1, 3);
    add(1, 8'h00, 0, 0, 1, 0, 3);
    add(0, 8'h00, 0, 1, 0, 0, 0);
    run_table("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
